// File: rtl/ld_st_mem_scheduler.sv
// Arbitrates the load-buffer head and the committed store-buffer head onto the
// single L2 request port. One request is outstanding at a time, and each load waits for its fill.
module ld_st_mem_scheduler #(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MICROOP    = 5,
  parameter int R_WIDTH    = 6,
  parameter int ROB_TICKET = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  input  logic [ADDR_BITS-1:0]  ld_head_address,
  input  logic [MICROOP-1:0]    ld_head_microop,
  input  logic [R_WIDTH-1:0]    ld_head_dest,
  input  logic [ROB_TICKET-1:0] ld_head_ticket,
  output logic                  ld_pop,
  input  logic                  st_valid,
  input  logic                  st_ready,
  input  logic                  st_head_committed,
  input  logic [ADDR_BITS-1:0]  st_head_address,
  input  logic [DATA_WIDTH-1:0] st_head_data,
  input  logic [MICROOP-1:0]    st_head_microop,
  output logic                  st_pop,
  output logic                  l2_req_valid,
  input  logic                  l2_req_ready,
  output logic                  l2_req_write,
  output logic [ADDR_BITS-1:0]  l2_req_address,
  output logic [DATA_WIDTH-1:0] l2_req_data,
  output logic [MICROOP-1:0]    l2_req_microop,
  input  logic                  l2_resp_valid,
  input  logic [DATA_WIDTH-1:0] l2_resp_data,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [R_WIDTH-1:0]    wb_dest,
  output logic [ROB_TICKET-1:0] wb_ticket,
  output logic                  busy
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           starve_cnt_q, starve_cnt_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [MICROOP-1:0]      uop_q, uop_d;
  logic [R_WIDTH-1:0]      dest_q, dest_d;
  logic [ROB_TICKET-1:0]   ticket_q, ticket_d;

  logic st_el, ld_el, grant_st, grant_ld;

  assign st_el = st_valid & st_head_committed;
  assign ld_el = ld_valid;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    uop_d        = uop_q;
    dest_d       = dest_q;
    ticket_d     = ticket_q;
    grant_st     = 1'b0;
    grant_ld     = 1'b0;

    case (state_q)
      IDLE: begin
        // A full store buffer or an exhausted starvation budget forces the store first.
        if (st_el && (!st_ready || starve_cnt_q == CNT_MAX)) grant_st = 1'b1;
        else if (ld_el)                                       grant_ld = 1'b1;
        else if (st_el)                                       grant_st = 1'b1;
      end
      ST_REQ:  if (l2_req_ready)  state_d = IDLE;
      LD_REQ:  if (l2_req_ready)  state_d = LD_WAIT;
      LD_WAIT: if (l2_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_st) begin
      state_d      = ST_REQ;
      addr_d       = st_head_address;
      data_d       = st_head_data;
      uop_d        = st_head_microop;
      starve_cnt_d = '0;
    end
    if (grant_ld) begin
      state_d  = LD_REQ;
      addr_d   = ld_head_address;
      data_d   = '0;
      uop_d    = ld_head_microop;
      dest_d   = ld_head_dest;
      ticket_d = ld_head_ticket;
      if (st_el && starve_cnt_q != CNT_MAX) starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      uop_q        <= '0;
      dest_q       <= '0;
      ticket_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      uop_q        <= uop_d;
      dest_q       <= dest_d;
      ticket_q     <= ticket_d;
    end
  end

  // Pops and writeback are qualified by rst_n so a reset cycle never retires an entry.
  assign l2_req_valid   = (state_q == ST_REQ) || (state_q == LD_REQ);
  assign l2_req_write   = (state_q == ST_REQ);
  assign l2_req_address = addr_q;
  assign l2_req_data    = l2_req_write ? data_q : '0;
  assign l2_req_microop = uop_q;
  assign st_pop         = rst_n && (state_q == ST_REQ) && l2_req_ready;
  assign wb_valid       = rst_n && (state_q == LD_WAIT) && l2_resp_valid;
  assign ld_pop         = wb_valid;
  assign wb_data        = wb_valid ? l2_resp_data : '0;
  assign wb_dest        = dest_q;
  assign wb_ticket      = ticket_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ld_st_mem_scheduler.sv
// Bench for ld_st_mem_scheduler: queue-backed load/store buffers and a
// transaction-level reference model, with directed scenarios then random traffic.
module tb_ld_st_mem_scheduler;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_pop;
  logic [31:0] ld_head_address;
  logic [4:0]  ld_head_microop;
  logic [5:0]  ld_head_dest;
  logic [2:0]  ld_head_ticket;
  logic        st_valid, st_ready, st_head_committed, st_pop;
  logic [31:0] st_head_address, st_head_data;
  logic [4:0]  st_head_microop;
  logic        l2_req_valid, l2_req_ready, l2_req_write;
  logic [31:0] l2_req_address, l2_req_data;
  logic [4:0]  l2_req_microop;
  logic        l2_resp_valid;
  logic [31:0] l2_resp_data;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [5:0]  wb_dest;
  logic [2:0]  wb_ticket;
  logic        busy;

  ld_st_mem_scheduler #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_head_address(ld_head_address), .ld_head_microop(ld_head_microop),
    .ld_head_dest(ld_head_dest), .ld_head_ticket(ld_head_ticket), .ld_pop(ld_pop),
    .st_valid(st_valid), .st_ready(st_ready), .st_head_committed(st_head_committed),
    .st_head_address(st_head_address), .st_head_data(st_head_data),
    .st_head_microop(st_head_microop), .st_pop(st_pop),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_write(l2_req_write),
    .l2_req_address(l2_req_address), .l2_req_data(l2_req_data), .l2_req_microop(l2_req_microop),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest), .wb_ticket(wb_ticket),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [4:0] u; logic [5:0] d; logic [2:0] t; } ld_ent_t;
  typedef struct { logic [31:0] a; logic [31:0] dt; logic [4:0] u; } st_ent_t;

  ld_ent_t ldq[$];
  st_ent_t stq[$];
  int      n_commit;
  logic    gseq[$];

  // stimulus knobs
  logic        k_rst = 1'b1, k_rdy = 1'b0, k_rsp = 1'b0, k_full = 1'b0;
  logic [31:0] k_rsp_data = '0;

  // reference model: is a transaction open, which kind, has the read been accepted
  bit          m_busy, m_st, m_acc;
  int          m_cnt;
  logic [31:0] m_addr, m_data;
  logic [4:0]  m_uop;
  logic [5:0]  m_dest;
  logic [2:0]  m_tkt;

  // last sampled outputs
  logic        o_req_valid, o_write, o_st_pop, o_ld_pop, o_wb_valid, o_busy;
  logic [31:0] o_addr, o_data, o_wb_data;
  logic [5:0]  o_wb_dest;
  logic [2:0]  o_wb_ticket;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_st = 0; m_acc = 0; m_cnt = 0;
    m_addr = '0; m_data = '0; m_uop = '0; m_dest = '0; m_tkt = '0;
  endtask

  task automatic drive();
    rst_n         = k_rst;
    l2_req_ready  = k_rdy;
    l2_resp_valid = k_rsp;
    l2_resp_data  = k_rsp ? k_rsp_data : $urandom;
    st_ready      = !k_full;
    ld_valid      = ldq.size() > 0;
    if (ld_valid) begin
      ld_head_address = ldq[0].a; ld_head_microop = ldq[0].u;
      ld_head_dest    = ldq[0].d; ld_head_ticket  = ldq[0].t;
    end else begin
      ld_head_address = $urandom; ld_head_microop = 5'($urandom);
      ld_head_dest    = 6'($urandom); ld_head_ticket = 3'($urandom);
    end
    st_valid          = stq.size() > 0;
    st_head_committed = n_commit > 0;
    if (st_valid) begin
      st_head_address = stq[0].a; st_head_data = stq[0].dt; st_head_microop = stq[0].u;
    end else begin
      st_head_address = $urandom; st_head_data = $urandom; st_head_microop = 5'($urandom);
    end
  endtask

  // One clock: drive, check at mid-cycle against the model, advance the model across the edge.
  task automatic step();
    bit e_req, e_wb, st_el, ld_el;
    drive();
    #4;
    o_req_valid = l2_req_valid; o_write = l2_req_write; o_st_pop = st_pop;
    o_ld_pop = ld_pop; o_wb_valid = wb_valid; o_busy = busy;
    o_addr = l2_req_address; o_data = l2_req_data; o_wb_data = wb_data;
    o_wb_dest = wb_dest; o_wb_ticket = wb_ticket;

    e_req = m_busy && (m_st || !m_acc);
    e_wb  = k_rst && m_busy && !m_st && m_acc && k_rsp;
    chk("busy", o_busy, m_busy);
    chk("req_valid", o_req_valid, e_req);
    chk("req_write", o_write, m_busy && m_st);
    chk("st_pop", o_st_pop, k_rst && m_busy && m_st && k_rdy);
    chk("ld_pop", o_ld_pop, e_wb);
    chk("wb_valid", o_wb_valid, e_wb);
    if (!o_write) chk("req_data_zero", o_data, 0);
    if (e_req) begin
      chk("req_addr", o_addr, m_addr);
      chk("req_uop", l2_req_microop, m_uop);
      if (m_st) chk("req_data", o_data, m_data);
    end
    if (e_wb) begin
      chk("wb_data", o_wb_data, k_rsp_data);
      chk("wb_dest", o_wb_dest, m_dest);
      chk("wb_ticket", o_wb_ticket, m_tkt);
    end
    if (o_req_valid && k_rdy && k_rst) gseq.push_back(o_write);

    st_el = stq.size() > 0 && n_commit > 0;
    ld_el = ldq.size() > 0;
    if (!k_rst) model_reset();
    else if (!m_busy) begin
      if (st_el && (k_full || m_cnt == SMAX) || (st_el && !ld_el)) begin
        m_busy = 1; m_st = 1; m_acc = 0; m_cnt = 0;
        m_addr = stq[0].a; m_data = stq[0].dt; m_uop = stq[0].u;
      end else if (ld_el) begin
        m_busy = 1; m_st = 0; m_acc = 0;
        if (st_el && m_cnt < SMAX) m_cnt++;
        m_addr = ldq[0].a; m_uop = ldq[0].u; m_dest = ldq[0].d; m_tkt = ldq[0].t;
      end
    end else if (m_st) begin
      if (k_rdy) begin m_busy = 0; void'(stq.pop_front()); n_commit--; end
    end else if (!m_acc) begin
      if (k_rdy) m_acc = 1;
    end else if (k_rsp) begin
      m_busy = 0; void'(ldq.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    k_rst = 0; k_rdy = 0; k_rsp = 0;
    step();
    k_rst = 1;
  endtask

  task automatic drain();
    int n = 0;
    k_full = 0; k_rdy = 1; k_rsp = 1;
    n_commit = stq.size();
    while ((ldq.size() > 0 || stq.size() > 0 || m_busy) && n < 200) begin
      k_rsp_data = $urandom;
      step(); n++;
    end
    if (n >= 200) chk("drain_timeout", 1, 0);
    k_rdy = 0; k_rsp = 0;
  endtask

  task automatic push_ld(input logic [31:0] a, input logic [4:0] u, input logic [5:0] d,
                         input logic [2:0] t);
    ld_ent_t e;
    e.a = a; e.u = u; e.d = d; e.t = t;
    ldq.push_back(e);
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] dt, input logic [4:0] u);
    st_ent_t e;
    e.a = a; e.dt = dt; e.u = u;
    stq.push_back(e);
  endtask

  initial begin
    n_commit = 0;
    model_reset();
    k_rst = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    k_rst = 1;
    step();
    chk("reset_busy", o_busy, 0);
    chk("reset_req_valid", o_req_valid, 0);

    // store only
    push_st(32'h100, 32'hDEADBEEF, 5'h11); n_commit = 1; k_rdy = 1;
    step();
    step();
    chk("t1_valid", o_req_valid, 1);
    chk("t1_write", o_write, 1);
    chk("t1_addr", o_addr, 32'h100);
    chk("t1_data", o_data, 32'hDEADBEEF);
    chk("t1_st_pop", o_st_pop, 1);
    step();
    chk("t1_idle", o_busy, 0);

    // load with backpressure, response two cycles after accept
    push_ld(32'h200, 5'h3, 6'd5, 3'd3); k_rdy = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      k_rdy = (i == 3);
      step();
      chk("t2_hold_valid", o_req_valid, 1);
      chk("t2_hold_addr", o_addr, 32'h200);
    end
    k_rdy = 0;
    step();
    chk("t2_wait_no_wb", o_wb_valid, 0);
    k_rsp = 1; k_rsp_data = 32'h1234;
    step();
    chk("t2_wb_valid", o_wb_valid, 1);
    chk("t2_wb_data", o_wb_data, 32'h1234);
    chk("t2_wb_dest", o_wb_dest, 5);
    chk("t2_wb_ticket", o_wb_ticket, 3);
    chk("t2_ld_pop", o_ld_pop, 1);
    k_rsp = 0;

    // starvation: four loads then the store
    do_reset();
    gseq.delete();
    for (int i = 0; i < 6; i++) push_ld(32'h1000 + 32'(i * 4), 5'h1, 6'(i), 3'(i));
    push_st(32'h300, 32'hA5A5A5A5, 5'h2); push_st(32'h304, 32'h5A5A5A5A, 5'h2);
    n_commit = 2; k_rdy = 1; k_rsp = 1; k_rsp_data = 32'hCAFE;
    for (int i = 0; i < 60 && gseq.size() < 6; i++) step();
    if (gseq.size() < 6) chk("t3_timeout", gseq.size(), 6);
    else begin
      for (int i = 0; i < 4; i++) chk("t3_load_first", gseq[i], 0);
      chk("t3_store_fifth", gseq[4], 1);
      chk("t3_load_after", gseq[5], 0);
    end
    drain();

    // store buffer full forces the store ahead of a pending load
    gseq.delete();
    push_ld(32'h400, 5'h4, 6'd9, 3'd1); push_st(32'h500, 32'h11223344, 5'h5);
    n_commit = 1; k_full = 1; k_rdy = 1; k_rsp = 1;
    for (int i = 0; i < 10 && gseq.size() < 1; i++) step();
    if (gseq.size() < 1) chk("t4_timeout", 0, 1);
    else chk("t4_store_first", gseq[0], 1);
    drain();

    // uncommitted store waits for its commit
    push_st(32'h600, 32'h77, 5'h6); n_commit = 0; k_rdy = 1;
    step(); step();
    chk("t5_idle_valid", o_req_valid, 0);
    chk("t5_idle_busy", o_busy, 0);
    n_commit = 1;
    step();
    step();
    chk("t5_issue_valid", o_req_valid, 1);
    chk("t5_issue_write", o_write, 1);
    drain();

    // reset while waiting for a fill
    push_ld(32'h700, 5'h7, 6'd12, 3'd6); k_rdy = 1; k_rsp = 0;
    step(); step();
    k_rdy = 0;
    step();
    chk("t6_in_wait", o_busy, 1);
    k_rst = 0; k_rsp = 1; k_rsp_data = 32'hBAD;
    step();
    chk("t6_rst_no_pop", o_ld_pop, 0);
    chk("t6_rst_no_wb", o_wb_valid, 0);
    k_rst = 1;
    step();
    chk("t6_after_busy", o_busy, 0);
    chk("t6_after_no_wb", o_wb_valid, 0);
    k_rsp = 0;
    drain();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 30 && ldq.size() < 8)
        push_ld($urandom, 5'($urandom), 6'($urandom), 3'($urandom));
      if ($urandom_range(0, 99) < 20 && stq.size() < 8)
        push_st($urandom, $urandom, 5'($urandom));
      if ($urandom_range(0, 99) < 30 && n_commit < stq.size()) n_commit++;
      k_rdy      = $urandom_range(0, 99) < 60;
      k_rsp      = $urandom_range(0, 99) < 40;
      k_full     = $urandom_range(0, 99) < 15;
      k_rst      = $urandom_range(0, 99) >= 1;
      k_rsp_data = $urandom;
      step();
    end
    k_rst = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ld_st_mem_scheduler.md
Name: ld_st_mem_scheduler

Overview:
- Sequences the load buffer and the store buffer onto the single memory-side request port of the L1 data cache (the L2 request channel).
- Each cycle it picks either the load-buffer head or the committed store-buffer head, issues one request with a valid/ready handshake, and pops the served entry.
- For loads it waits for the fill response, then produces the register writeback.
- It sits between the two ld/st FIFO buffers and the L2 interface, inside the data-cache top.

Parameters:
- ADDR_BITS, 32, address width
- DATA_WIDTH, 32, data width
- MICROOP, 5, microop field width
- R_WIDTH, 6, destination register tag width
- ROB_TICKET, 3, ROB ticket width
- STARVE_MAX, 4, maximum consecutive loads granted while a committed store waits

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- ld_valid  in  1  load buffer non-empty
- ld_head_address  in  ADDR_BITS  load head address
- ld_head_microop  in  MICROOP  load head microop
- ld_head_dest  in  R_WIDTH  load head destination tag
- ld_head_ticket  in  ROB_TICKET  load head ROB ticket
- ld_pop  out  1  pop load buffer head
- st_valid  in  1  store buffer non-empty
- st_ready  in  1  store buffer not full
- st_head_committed  in  1  store head retired by ROB, may be written
- st_head_address  in  ADDR_BITS  store head address
- st_head_data  in  DATA_WIDTH  store head data
- st_head_microop  in  MICROOP  store head microop
- st_pop  out  1  pop store buffer head
- l2_req_valid  out  1  request valid
- l2_req_ready  in  1  L2 accepts request
- l2_req_write  out  1  1 = store, 0 = load read
- l2_req_address  out  ADDR_BITS  request address
- l2_req_data  out  DATA_WIDTH  store data (0 for loads)
- l2_req_microop  out  MICROOP  request microop
- l2_resp_valid  in  1  read response valid
- l2_resp_data  in  DATA_WIDTH  read response data
- wb_valid  out  1  load writeback strobe
- wb_data  out  DATA_WIDTH  writeback data
- wb_dest  out  R_WIDTH  writeback destination tag
- wb_ticket  out  ROB_TICKET  writeback ROB ticket
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ST_REQ, LD_REQ, LD_WAIT. rst_n sampled low at a clk edge -> IDLE, starve_cnt=0, latched request fields 0.
- Reset outputs, and all outputs in IDLE: l2_req_valid=0, l2_req_write=0, st_pop=0, ld_pop=0, wb_valid=0, busy=0.
- A reset mid-operation abandons any outstanding request or response; no pop and no writeback are issued.
- Eligibility: st_el = st_valid & st_head_committed; ld_el = ld_valid.
- IDLE grant, evaluated in priority order:
  1. st_el & (~st_ready | starve_cnt==STARVE_MAX) -> grant store.
  2. Else ld_el -> grant load.
  3. Else st_el -> grant store.
  4. Else stay in IDLE.
- On a grant, the head fields are latched into request registers. Next state is ST_REQ or LD_REQ.
- starve_cnt:
  - +1, saturating at STARVE_MAX, when a load is granted while st_el=1.
  - Cleared to 0 when a store is granted.
  - Unchanged otherwise.
  - Width is clog2(STARVE_MAX+1).
- ST_REQ and LD_REQ:
  - l2_req_valid=1; address, data, microop and write come from the latched registers.
  - These outputs stay stable while l2_req_ready=0. The request is never withdrawn.
- ST_REQ with l2_req_ready=1: st_pop=1 combinationally in the same cycle, then -> IDLE.
- LD_REQ with l2_req_ready=1: -> LD_WAIT. The load is not popped yet.
- LD_WAIT:
  - l2_req_valid=0.
  - On l2_resp_valid=1, in the same cycle: wb_valid=1, wb_data=l2_resp_data, wb_dest and wb_ticket from latched registers, ld_pop=1. Then -> IDLE.
- l2_resp_valid is ignored in every state other than LD_WAIT.
- Latency:
  - Minimum per store is 2 cycles (grant, accept).
  - Minimum per load is 3 cycles (grant, accept, response).
  - Only one request is outstanding at any time.
- Head changes while in a REQ or WAIT state do not affect the latched request. Only the served entry is popped, and only once.
- st_pop and ld_pop are never asserted in the same cycle, and each is at most a 1-cycle pulse.
- l2_req_data=0 whenever l2_req_write=0.

Test Plan:
- Store only: st_valid=1, st_head_committed=1, address 0x100, data 0xDEADBEEF, l2_req_ready=1 -> cycle 1: l2_req_valid=1, write=1, addr 0x100, data 0xDEADBEEF, st_pop=1; cycle 2: IDLE.
- Load with backpressure: ld head addr 0x200, dest 5, ticket 3; l2_req_ready=0 for 3 cycles -> request held stable for 4 cycles. Response 0x1234 two cycles after accept -> wb_valid=1, wb_data=0x1234, wb_dest=5, wb_ticket=3, ld_pop=1, all in the same cycle.
- Starvation, STARVE_MAX=4: committed store and loads pending continuously, st_ready=1 -> 4 loads granted, 5th grant is the store, starve_cnt returns to 0.
- Store buffer full: st_ready=0 with a committed store and a pending load -> store granted first regardless of starve_cnt.
- Uncommitted store: st_valid=1, st_head_committed=0, ld_valid=0 -> stays IDLE, l2_req_valid=0. Raising committed -> store issued next cycle.
- Reset during LD_WAIT: rst_n=0 for one edge -> next cycle busy=0, no wb_valid and no ld_pop, and a late l2_resp_valid is ignored.
